usb_dev_responder: RTL and testbench
====================================

// Module: usb_dev_responder
// PURPOSE
//  Device-side USB transaction responder: the far end of the host controller's token/data/handshake exchange.
//  Consumes decoded tokens and packets from a device packet receiver and answers OUT/SETUP with ACK/NAK/STALL and IN with DATA0/1 or NAK/STALL.
//  Tracks per-endpoint data toggles and enforces the handshake turnaround timeout.
//  Sits between the device PHY packet codec and the endpoint buffers.
// PARAMETERS
//  NUM_EP   4   endpoints implemented (0..NUM_EP-1)
//  MAX_PKT  64  max data payload bytes; LEN_W = $clog2(MAX_PKT+1)
//  TIMEOUT  72  SIE_clk cycles allowed for the host's data/handshake after our last event
// PORTS
//  SIE_clk        in   1       clock
//  reset          in   1       synchronous, active-low reset
//  dev_addr       in   7       configured device address
//  ep_stall       in   NUM_EP  per-endpoint halt
//  tok_valid      in   1       1-cycle pulse: token decoded, CRC5 good
//  tok_pid        in   4       token PID
//  tok_addr       in   7       token address
//  tok_ep         in   4       token endpoint
//  rx_byte_valid  in   1       payload byte strobe of the current data packet
//  rx_byte        in   8       payload byte
//  rx_pkt_valid   in   1       1-cycle pulse: end of non-token packet
//  rx_pid         in   4       PID of that packet
//  rx_crc_ok      in   1       CRC16 good, qualified by rx_pkt_valid
//  out_space      in   NUM_EP  endpoint can take MAX_PKT bytes
//  out_wr_en      out  1       write rx_byte to the OUT buffer of out_ep
//  out_wr_data    out  8       byte to write
//  out_ep         out  4       endpoint of the current transaction
//  out_commit     out  1       pulse: keep the written packet; out_len valid
//  out_discard    out  1       pulse: drop the written packet
//  out_len        out  LEN_W   committed length
//  out_setup      out  1       qualifies out_commit as a SETUP packet
//  in_avail       in   NUM_EP  IN packet ready on that endpoint
//  in_len         in   LEN_W   length of the packet on out_ep
//  in_rd_en       out  1       pop one IN byte
//  in_rd_data     in   8       IN byte, valid on the cycle after in_rd_en
//  in_done        out  1       pulse: host ACKed; release the IN buffer
//  tx_start       out  1       pulse: send packet tx_pid, tx_len bytes
//  tx_pid         out  4       PID to send
//  tx_len         out  LEN_W   0 for handshakes
//  tx_byte_rd     in   1       transmitter pulls the next byte
//  tx_byte        out  8       = in_rd_data
//  tx_done        in   1       pulse: last bit on the wire
//  err_timeout    out  1       pulse: turnaround timeout
//  err_crc        out  1       pulse: bad CRC16 or babble
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, all toggles 0, timer 0. Reset mid-transaction aborts silently with no out_discard.
//  - PIDs (usb_pid_defs.vh): OUT 0001, IN 1001, SETUP 1101, SOF 0101, PING 0100, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
//  - A token is accepted only in IDLE with tok_addr==dev_addr and tok_ep<NUM_EP. Ignored otherwise: SOF, tokens in any other state.
//  - States: IDLE, RX_DATA, TX_HS, IN_TX, IN_WAIT_HS.
//  - OUT/SETUP -> RX_DATA and start the timer; out_ep=tok_ep.
//  - RX_DATA:
//    - Each rx_byte_valid drives out_wr_en in the next cycle and increments the count.
//    - Count > MAX_PKT: babble; at rx_pkt_valid, err_crc and out_discard.
//    - rx_pkt_valid with DATAx: CRC bad -> err_crc and out_discard, no reply, IDLE.
//    - SETUP: always ACK and commit; set OUT and IN toggles of that endpoint to 1; out_setup=1.
//    - OUT, priority order: ep_stall -> STALL and discard; !out_space -> NAK and discard; DATAx != toggle -> ACK and discard, toggle unchanged; else ACK, commit, flip OUT toggle.
//    - Non-DATA PID or timer==TIMEOUT -> err_timeout (timeout only), out_discard, IDLE.
//  - TX_HS: tx_start with tx_len=0, hold until tx_done, then IDLE.
//  - IN, priority order: ep_stall -> STALL; !in_avail -> NAK (TX_HS for both); else tx_start with DATA<IN toggle>, tx_len=in_len -> IN_TX.
//  - IN_TX: in_rd_en = tx_byte_rd; tx_done -> IN_WAIT_HS and clear the timer.
//  - IN_WAIT_HS:
//    - rx_pkt_valid with ACK -> in_done, flip IN toggle, IDLE.
//    - Any other packet or timer==TIMEOUT -> err_timeout, toggle kept, buffer kept for retry.
//    - A tok_valid arriving here counts as a timeout and is dropped.
//  - tx_start, out_commit, out_discard, in_done and err_* are single-cycle. The reply tx_start is one cycle after rx_pkt_valid.
//  - Timer: LEN-independent, saturates at TIMEOUT, cleared on every state entry.
// CONFIGURATION
//  - USB_DEV_PING_EN defined: a PING token to this device -> ACK if out_space[ep] else NAK (STALL if ep_stall), via TX_HS.
//  - Not defined: PING is ignored like SOF.
// STRUCTURE
//  - usb_pid_defs.vh: PID localparams and the state encoding.
//  - One sub-module, usb_dev_toggle_file: 2*NUM_EP toggle bits; ports set/flip/read per direction.
//  - The FSM, timer and byte counter stay in usb_dev_responder.
// TESTING
//  - OUT ep1, DATA0, 8 bytes, CRC ok, out_space=1, toggle 0 -> 8 out_wr_en, out_commit with out_len=8, ACK sent, OUT toggle becomes 1.
//  - Repeat the same DATA0 -> ACK and out_discard, toggle stays 1.
//  - SETUP ep0, 8 bytes -> ACK, out_setup=1; next IN ep0 with in_avail=1, in_len=2 -> DATA1, 2 bytes, host ACK -> in_done, IN toggle becomes 0.
//  - IN ep2 with ep_stall[2]=1 -> STALL, tx_len=0; IN ep3 with in_avail=0 -> NAK.
//  - IN ep1 sent, no handshake for 72 cycles -> err_timeout, no in_done, toggle unchanged; retry resends the same DATAx.
//  - OUT with bad CRC -> err_crc, out_discard, no tx_start.
//  - 65 bytes -> err_crc.
//  - Token with tok_addr != dev_addr -> no activity.
//  - With USB_DEV_PING_EN: PING with out_space=0 -> NAK; without: no tx_start.

Source files
------------

// File: rtl/usb_dev_responder_pkg.sv
// Shared USB PID encodings and responder state encoding for the device-side transaction responder.
package usb_dev_responder_pkg;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidSof   = 4'b0101;
  localparam logic [3:0] PidPing  = 4'b0100;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  typedef enum logic [2:0] {
    StIdle,
    StRxData,
    StTxHs,
    StInTx,
    StInWaitHs
  } state_e;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PidData0) || (pid == PidData1);
  endfunction

endpackage

// File: rtl/usb_dev_toggle_file.sv
// Per-endpoint DATA0/DATA1 toggle bits, one for the OUT and one for the IN direction.
module usb_dev_toggle_file #(
  parameter int unsigned NUM_EP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        ep_i,
  input  logic              out_set_i,
  input  logic              out_flip_i,
  input  logic              in_set_i,
  input  logic              in_flip_i,
  output logic [NUM_EP-1:0] out_tog_o,
  output logic [NUM_EP-1:0] in_tog_o
);

  logic [NUM_EP-1:0] out_q, out_d;
  logic [NUM_EP-1:0] in_q, in_d;

  always_comb begin
    out_d = out_q;
    in_d  = in_q;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (ep_i == 4'(i)) begin
        if (out_set_i)       out_d[i] = 1'b1;
        else if (out_flip_i) out_d[i] = ~out_q[i];
        if (in_set_i)        in_d[i]  = 1'b1;
        else if (in_flip_i)  in_d[i]  = ~in_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q <= '0;
      in_q  <= '0;
    end else begin
      out_q <= out_d;
      in_q  <= in_d;
    end
  end

  assign out_tog_o = out_q;
  assign in_tog_o  = in_q;

endmodule

// File: rtl/usb_dev_responder.sv
// Device-side USB token/data/handshake responder with per-endpoint toggles and turnaround timeout.
// Define USB_DEV_PING_EN to answer PING tokens; otherwise PING is ignored like SOF.
module usb_dev_responder
  import usb_dev_responder_pkg::*;
#(
  parameter int unsigned NUM_EP  = 4,
  parameter int unsigned MAX_PKT = 64,
  parameter int unsigned TIMEOUT = 72,
  localparam int unsigned LEN_W  = $clog2(MAX_PKT + 1)
) (
  input  logic              SIE_clk,
  input  logic              reset,
  input  logic [6:0]        dev_addr,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic              tok_valid,
  input  logic [3:0]        tok_pid,
  input  logic [6:0]        tok_addr,
  input  logic [3:0]        tok_ep,
  input  logic              rx_byte_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_pkt_valid,
  input  logic [3:0]        rx_pid,
  input  logic              rx_crc_ok,
  input  logic [NUM_EP-1:0] out_space,
  output logic              out_wr_en,
  output logic [7:0]        out_wr_data,
  output logic [3:0]        out_ep,
  output logic              out_commit,
  output logic              out_discard,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_setup,
  input  logic [NUM_EP-1:0] in_avail,
  input  logic [LEN_W-1:0]  in_len,
  output logic              in_rd_en,
  input  logic [7:0]        in_rd_data,
  output logic              in_done,
  output logic              tx_start,
  output logic [3:0]        tx_pid,
  output logic [LEN_W-1:0]  tx_len,
  input  logic              tx_byte_rd,
  output logic [7:0]        tx_byte,
  input  logic              tx_done,
  output logic              err_timeout,
  output logic              err_crc
);

  // One extra count value so a babbling packet is still visible after MAX_PKT bytes.
  localparam int unsigned CNT_W = $clog2(MAX_PKT + 2);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PKT);
  localparam logic [TMR_W-1:0] TmrMax = TMR_W'(TIMEOUT);

  function automatic logic ep_bit(input logic [NUM_EP-1:0] v, input logic [3:0] ep);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (ep == 4'(i)) r = v[i];
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         ep_q, ep_d;
  logic               setup_q, setup_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               wr_en_q, wr_en_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               commit_q, commit_d, discard_q, discard_d, setup_out_q, setup_out_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;
  logic               in_done_q, in_done_d;
  logic               tx_start_q, tx_start_d;
  logic [3:0]         tx_pid_q, tx_pid_d;
  logic [LEN_W-1:0]   tx_len_q, tx_len_d;
  logic               err_to_q, err_to_d, err_crc_q, err_crc_d;
  logic               out_set, out_flip, in_set, in_flip;
  logic [NUM_EP-1:0]  out_tog, in_tog;
  logic               tok_hit;

  usb_dev_toggle_file #(
    .NUM_EP(NUM_EP)
  ) u_toggle (
    .clk_i     (SIE_clk),
    .rst_ni    (reset),
    .ep_i      (ep_q),
    .out_set_i (out_set),
    .out_flip_i(out_flip),
    .in_set_i  (in_set),
    .in_flip_i (in_flip),
    .out_tog_o (out_tog),
    .in_tog_o  (in_tog)
  );

  assign tok_hit = tok_valid && (tok_addr == dev_addr) && (32'(tok_ep) < NUM_EP);

  always_comb begin
    state_d     = state_q;
    ep_d        = ep_q;
    setup_d     = setup_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    commit_d    = 1'b0;
    discard_d   = 1'b0;
    setup_out_d = 1'b0;
    out_len_d   = out_len_q;
    in_done_d   = 1'b0;
    tx_start_d  = 1'b0;
    tx_pid_d    = tx_pid_q;
    tx_len_d    = tx_len_q;
    err_to_d    = 1'b0;
    err_crc_d   = 1'b0;
    out_set     = 1'b0;
    out_flip    = 1'b0;
    in_set      = 1'b0;
    in_flip     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tok_hit) begin
          case (tok_pid)
            PidOut, PidSetup: begin
              ep_d    = tok_ep;
              setup_d = (tok_pid == PidSetup);
              cnt_d   = '0;
              state_d = StRxData;
            end
            PidIn: begin
              ep_d       = tok_ep;
              tx_start_d = 1'b1;
              tx_len_d   = '0;
              state_d    = StTxHs;
              if (ep_bit(ep_stall, tok_ep)) begin
                tx_pid_d = PidStall;
              end else if (!ep_bit(in_avail, tok_ep)) begin
                tx_pid_d = PidNak;
              end else begin
                tx_pid_d = ep_bit(in_tog, tok_ep) ? PidData1 : PidData0;
                tx_len_d = in_len;
                state_d  = StInTx;
              end
            end
`ifdef USB_DEV_PING_EN
            PidPing: begin
              ep_d       = tok_ep;
              tx_start_d = 1'b1;
              tx_len_d   = '0;
              state_d    = StTxHs;
              if (ep_bit(ep_stall, tok_ep))       tx_pid_d = PidStall;
              else if (ep_bit(out_space, tok_ep)) tx_pid_d = PidAck;
              else                                tx_pid_d = PidNak;
            end
`endif
            default: ;
          endcase
        end
      end

      StRxData: begin
        if (rx_byte_valid) begin
          if (cnt_q < MaxCnt) begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_byte;
          end
          if (cnt_q <= MaxCnt) cnt_d = cnt_q + CNT_W'(1);
        end
        if (rx_pkt_valid) begin
          state_d = StIdle;
          if (!is_data_pid(rx_pid)) begin
            err_to_d  = 1'b1;
            discard_d = 1'b1;
          end else if (cnt_q > MaxCnt || !rx_crc_ok) begin
            err_crc_d = 1'b1;
            discard_d = 1'b1;
          end else begin
            tx_start_d = 1'b1;
            tx_len_d   = '0;
            tx_pid_d   = PidAck;
            state_d    = StTxHs;
            if (setup_q) begin
              commit_d    = 1'b1;
              setup_out_d = 1'b1;
              out_len_d   = LEN_W'(cnt_q);
              out_set     = 1'b1;
              in_set      = 1'b1;
            end else if (ep_bit(ep_stall, ep_q)) begin
              tx_pid_d  = PidStall;
              discard_d = 1'b1;
            end else if (!ep_bit(out_space, ep_q)) begin
              tx_pid_d  = PidNak;
              discard_d = 1'b1;
            end else if (rx_pid[3] != ep_bit(out_tog, ep_q)) begin
              // Host retried a packet we already took: ACK again but drop the copy.
              discard_d = 1'b1;
            end else begin
              commit_d  = 1'b1;
              out_len_d = LEN_W'(cnt_q);
              out_flip  = 1'b1;
            end
          end
        end else if (tmr_q == TmrMax) begin
          err_to_d  = 1'b1;
          discard_d = 1'b1;
          state_d   = StIdle;
        end
      end

      StTxHs: begin
        if (tx_done) state_d = StIdle;
      end

      StInTx: begin
        if (tx_done) state_d = StInWaitHs;
      end

      StInWaitHs: begin
        if (rx_pkt_valid) begin
          state_d = StIdle;
          if (rx_pid == PidAck) begin
            in_done_d = 1'b1;
            in_flip   = 1'b1;
          end else begin
            err_to_d = 1'b1;
          end
        end else if (tok_valid || tmr_q == TmrMax) begin
          err_to_d = 1'b1;
          state_d  = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (state_q == StIdle || state_d != state_q) tmr_d = '0;
    else if (tmr_q == TmrMax)                    tmr_d = tmr_q;
    else                                         tmr_d = tmr_q + TMR_W'(1);
  end

  always_ff @(posedge SIE_clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      ep_q        <= '0;
      setup_q     <= 1'b0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      commit_q    <= 1'b0;
      discard_q   <= 1'b0;
      setup_out_q <= 1'b0;
      out_len_q   <= '0;
      in_done_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_pid_q    <= '0;
      tx_len_q    <= '0;
      err_to_q    <= 1'b0;
      err_crc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ep_q        <= ep_d;
      setup_q     <= setup_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      commit_q    <= commit_d;
      discard_q   <= discard_d;
      setup_out_q <= setup_out_d;
      out_len_q   <= out_len_d;
      in_done_q   <= in_done_d;
      tx_start_q  <= tx_start_d;
      tx_pid_q    <= tx_pid_d;
      tx_len_q    <= tx_len_d;
      err_to_q    <= err_to_d;
      err_crc_q   <= err_crc_d;
    end
  end

  // The buffer side sees the new endpoint already in the token cycle so in_len is for it.
  assign out_ep      = (state_q == StIdle && tok_hit) ? tok_ep : ep_q;
  assign out_wr_en   = wr_en_q;
  assign out_wr_data = wr_data_q;
  assign out_commit  = commit_q;
  assign out_discard = discard_q;
  assign out_len     = out_len_q;
  assign out_setup   = setup_out_q;
  assign in_done     = in_done_q;
  assign in_rd_en    = (state_q == StInTx) && tx_byte_rd;
  assign tx_byte     = (state_q == StInTx) ? in_rd_data : 8'h00;
  assign tx_start    = tx_start_q;
  assign tx_pid      = tx_pid_q;
  assign tx_len      = tx_len_q;
  assign err_timeout = err_to_q;
  assign err_crc     = err_crc_q;

endmodule

// File: tb/tb_usb_dev_responder.sv
// Directed scoreboard bench for usb_dev_responder; PING checks follow USB_DEV_PING_EN.
module tb_usb_dev_responder;
  import usb_dev_responder_pkg::*;

  localparam int unsigned NUM_EP = 4;
  localparam int unsigned LEN_W  = 7;
  localparam logic [6:0]  DevAddr = 7'h05;

  localparam int EvCommit  = 0;
  localparam int EvDiscard = 1;
  localparam int EvErrCrc  = 2;
  localparam int EvErrTo   = 3;
  localparam int EvTx      = 4;
  localparam int EvInDone  = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic              clk, rst_n;
  logic [6:0]        dev_addr;
  logic [NUM_EP-1:0] ep_stall, out_space, in_avail;
  logic              tok_valid;
  logic [3:0]        tok_pid, tok_ep, rx_pid;
  logic [6:0]        tok_addr;
  logic              rx_byte_valid, rx_pkt_valid, rx_crc_ok;
  logic [7:0]        rx_byte, in_rd_data;
  logic              out_wr_en, out_commit, out_discard, out_setup;
  logic [7:0]        out_wr_data, tx_byte;
  logic [3:0]        out_ep, tx_pid;
  logic [LEN_W-1:0]  out_len, in_len, tx_len;
  logic              in_rd_en, in_done, tx_start, tx_byte_rd, tx_done;
  logic              err_timeout, err_crc;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic mon_en   = 1'b0;
  ev_t         exp_q[$];
  logic [31:0] byte_q[$];

  usb_dev_responder dut (
    .SIE_clk      (clk),
    .reset        (rst_n),
    .dev_addr     (dev_addr),
    .ep_stall     (ep_stall),
    .tok_valid    (tok_valid),
    .tok_pid      (tok_pid),
    .tok_addr     (tok_addr),
    .tok_ep       (tok_ep),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte      (rx_byte),
    .rx_pkt_valid (rx_pkt_valid),
    .rx_pid       (rx_pid),
    .rx_crc_ok    (rx_crc_ok),
    .out_space    (out_space),
    .out_wr_en    (out_wr_en),
    .out_wr_data  (out_wr_data),
    .out_ep       (out_ep),
    .out_commit   (out_commit),
    .out_discard  (out_discard),
    .out_len      (out_len),
    .out_setup    (out_setup),
    .in_avail     (in_avail),
    .in_len       (in_len),
    .in_rd_en     (in_rd_en),
    .in_rd_data   (in_rd_data),
    .in_done      (in_done),
    .tx_start     (tx_start),
    .tx_pid       (tx_pid),
    .tx_len       (tx_len),
    .tx_byte_rd   (tx_byte_rd),
    .tx_byte      (tx_byte),
    .tx_done      (tx_done),
    .err_timeout  (err_timeout),
    .err_crc      (err_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input string tag, input int kind, input logic [31:0] a,
                        input logic [31:0] b);
    ev_t e;
    check({tag, "_expected"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_kind"}, kind, e.kind);
      check({tag, "_a"}, a, e.a);
      check({tag, "_b"}, b, e.b);
    end
  endtask

  task automatic got_wr();
    check("wr_expected", 32'(byte_q.size() != 0), 1);
    if (byte_q.size() != 0) check("wr_ep_byte", {20'h0, out_ep, out_wr_data}, byte_q.pop_front());
  endtask

  // Scoreboard side: same-cycle events are taken in a fixed order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_wr_en)   got_wr();
      if (out_commit)  got_ev("commit", EvCommit, (32'(out_ep) << 8) | 32'(out_len),
                              32'(out_setup));
      if (out_discard) got_ev("discard", EvDiscard, 32'(out_ep), 0);
      if (err_crc)     got_ev("err_crc", EvErrCrc, 0, 0);
      if (err_timeout) got_ev("err_timeout", EvErrTo, 0, 0);
      if (tx_start)    got_ev("tx_start", EvTx, 32'(tx_pid), 32'(tx_len));
      if (in_done)     got_ev("in_done", EvInDone, 32'(out_ep), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    tok_valid = 1'b1;
    tok_pid   = pid;
    tok_addr  = addr;
    tok_ep    = ep;
    tick(1);
    tok_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] pid, input bit crc_ok);
    rx_pkt_valid = 1'b1;
    rx_pid       = pid;
    rx_crc_ok    = crc_ok;
    tick(1);
    rx_pkt_valid = 1'b0;
    rx_crc_ok    = 1'b0;
  endtask

  // Token plus data packet; bytes the responder should store are queued for the scoreboard.
  task automatic send_out(input logic [3:0] tpid, input logic [6:0] addr, input logic [3:0] ep,
                          input logic [3:0] dpid, input int n, input bit crc_ok,
                          input logic [7:0] seed, input bit stored);
    send_token(tpid, addr, ep);
    for (int i = 0; i < n; i++) begin
      rx_byte_valid = 1'b1;
      rx_byte       = seed + 8'(i);
      if (stored && i < 64) byte_q.push_back({20'h0, ep, rx_byte});
      tick(1);
    end
    rx_byte_valid = 1'b0;
    tick(1);
    send_pkt(dpid, crc_ok);
  endtask

  // Plays the transmitter: wait for tx_start, pull n bytes, then report tx_done.
  task automatic phy_send(input int n, input logic [7:0] base);
    for (int k = 0; k < 20 && !tx_start; k++) @(negedge clk);
    check("tx_start_seen", 32'(tx_start), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      tx_byte_rd = 1'b1;
      #1 check("in_rd_en", 32'(in_rd_en), 1);
      @(posedge clk);
      #1;
      tx_byte_rd = 1'b0;
      in_rd_data = base + 8'(i);
      #1 check("tx_byte", 32'(tx_byte), 32'(base + 8'(i)));
    end
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300 && (exp_q.size() != 0 || byte_q.size() != 0); k++) tick(1);
    check(tag, exp_q.size() + byte_q.size(), 0);
    tick(4);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    dev_addr = DevAddr;
    ep_stall = '0;
    out_space = '1;
    in_avail = '0;
    tok_valid = 1'b0;
    tok_pid = '0;
    tok_addr = '0;
    tok_ep = '0;
    rx_byte_valid = 1'b0;
    rx_byte = '0;
    rx_pkt_valid = 1'b0;
    rx_pid = '0;
    rx_crc_ok = 1'b0;
    in_len = '0;
    in_rd_data = '0;
    tx_byte_rd = 1'b0;
    tx_done = 1'b0;
    tick(3);
    check("rst_pulses", {25'h0, out_wr_en, out_commit, out_discard, in_done, tx_start,
                         err_timeout, err_crc}, 0);
    check("rst_tx_pid_len", {21'h0, tx_pid, tx_len}, 0);
    check("rst_out_ep_len", {21'h0, out_ep, out_len}, 0);
    check("rst_misc", {29'h0, out_setup, in_rd_en, |out_wr_data}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // OUT ep1 DATA0 x8, toggle 0 -> commit, ACK
    push_ev(EvCommit, (1 << 8) | 8, 0);
    push_ev(EvTx, PidAck, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData0, 8, 1'b1, 8'h10, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("out_ep1_first");

    // Same DATA0 again -> ACK but discard
    push_ev(EvDiscard, 1, 0);
    push_ev(EvTx, PidAck, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData0, 8, 1'b1, 8'h10, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("out_ep1_repeat");

    // DATA1 matches the flipped toggle -> commit, toggle back to 0
    push_ev(EvCommit, (1 << 8) | 4, 0);
    push_ev(EvTx, PidAck, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData1, 4, 1'b1, 8'h40, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("out_ep1_data1");

    // SETUP ep0 -> ACK, commit with out_setup
    push_ev(EvCommit, (0 << 8) | 8, 1);
    push_ev(EvTx, PidAck, 0);
    send_out(PidSetup, DevAddr, 4'd0, PidData0, 8, 1'b1, 8'h80, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("setup_ep0");

    // IN ep0 after SETUP -> DATA1, host ACK -> in_done
    in_avail = 4'b0011;
    in_len = 7'd2;
    push_ev(EvTx, PidData1, 2);
    send_token(PidIn, DevAddr, 4'd0);
    phy_send(2, 8'hA0);
    push_ev(EvInDone, 0, 0);
    send_pkt(PidAck, 1'b1);
    wait_drain("in_ep0_data1");

    // IN toggle of ep0 is now 0
    push_ev(EvTx, PidData0, 2);
    send_token(PidIn, DevAddr, 4'd0);
    phy_send(2, 8'hB0);
    push_ev(EvInDone, 0, 0);
    send_pkt(PidAck, 1'b1);
    wait_drain("in_ep0_data0");

    // Halted and empty endpoints
    ep_stall = 4'b0100;
    in_avail = 4'b1110;
    push_ev(EvTx, PidStall, 0);
    send_token(PidIn, DevAddr, 4'd2);
    phy_send(0, 8'h00);
    wait_drain("in_ep2_stall");
    in_avail = 4'b0110;
    push_ev(EvTx, PidNak, 0);
    send_token(PidIn, DevAddr, 4'd3);
    phy_send(0, 8'h00);
    wait_drain("in_ep3_nak");

    // OUT to a halted endpoint -> STALL and discard
    push_ev(EvDiscard, 2, 0);
    push_ev(EvTx, PidStall, 0);
    send_out(PidOut, DevAddr, 4'd2, PidData0, 2, 1'b1, 8'h20, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("out_ep2_stall");
    ep_stall = '0;

    // IN ep1 with no handshake -> timeout, then retry resends DATA0
    in_len = 7'd3;
    push_ev(EvTx, PidData0, 3);
    push_ev(EvErrTo, 0, 0);
    send_token(PidIn, DevAddr, 4'd1);
    phy_send(3, 8'hC0);
    k = 0;
    while (!err_timeout && k < 150) begin
      tick(1);
      k++;
    end
    check("in_hs_timeout_delay", 32'(k >= 72 && k <= 74), 1);
    wait_drain("in_ep1_timeout");
    push_ev(EvTx, PidData0, 3);
    send_token(PidIn, DevAddr, 4'd1);
    phy_send(3, 8'hC0);
    push_ev(EvInDone, 1, 0);
    send_pkt(PidAck, 1'b1);
    wait_drain("in_ep1_retry");

    // Bad CRC -> err_crc and discard, no reply
    push_ev(EvDiscard, 1, 0);
    push_ev(EvErrCrc, 0, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData0, 4, 1'b0, 8'h50, 1'b1);
    wait_drain("out_bad_crc");

    // Babble: 65 bytes, only 64 stored
    push_ev(EvDiscard, 1, 0);
    push_ev(EvErrCrc, 0, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData0, 65, 1'b1, 8'h00, 1'b1);
    wait_drain("out_babble");

    // No room -> NAK and discard
    out_space = 4'b1101;
    push_ev(EvDiscard, 1, 0);
    push_ev(EvTx, PidNak, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData0, 3, 1'b1, 8'h60, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("out_no_space");

    // PING with no room
`ifdef USB_DEV_PING_EN
    push_ev(EvTx, PidNak, 0);
    send_token(PidPing, DevAddr, 4'd1);
    phy_send(0, 8'h00);
`else
    send_token(PidPing, DevAddr, 4'd1);
`endif
    wait_drain("ping_ep1");
    out_space = '1;

    // OUT token with no data -> RX timeout
    push_ev(EvDiscard, 1, 0);
    push_ev(EvErrTo, 0, 0);
    send_token(PidOut, DevAddr, 4'd1);
    wait_drain("out_rx_timeout");

    // Ignored tokens: wrong address, endpoint out of range, SOF
    send_out(PidOut, DevAddr + 7'd1, 4'd1, PidData0, 4, 1'b1, 8'h70, 1'b0);
    send_token(PidIn, DevAddr + 7'd1, 4'd1);
    send_token(PidIn, DevAddr, 4'd5);
    send_token(PidSof, DevAddr, 4'd0);
    tick(10);
    wait_drain("ignored_tokens");

    // Toggle of ep1 OUT must still be 0 after all discards
    push_ev(EvCommit, (1 << 8) | 2, 0);
    push_ev(EvTx, PidAck, 0);
    send_out(PidOut, DevAddr, 4'd1, PidData0, 2, 1'b1, 8'h90, 1'b1);
    phy_send(0, 8'h00);
    wait_drain("out_ep1_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end before 500000");
    $fatal(1);
  end

endmodule
